sobel_window: RTL

Streaming 3x3 window generator placed directly upstream of the combinational `sobel` kernel. It accepts one 8-bit grayscale pixel per enabled cycle in raster order and buffers the two previous image lines. Once a full neighbourhood exists, it presents the 3x3 window on nine registered outputs, `s11`..`s33`, which connect one-to-one to the kernel inputs. It also flags valid windows and the last window of each frame.

---
 rtl/sobel_window.sv | 125 ++++++++++++
 1 files changed

// File: rtl/sobel_window.sv
// Streaming 3x3 neighbourhood generator feeding the sobel kernel.
// Two line buffers hold the previous lines; the window and its position flags are registered.
module sobel_window #(
  parameter int IMG_W = 352,
  parameter int IMG_H = 288
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 pix_in,
  input  logic                       pix_valid,
  input  logic                       sof,
  output logic [7:0]                 s11,
  output logic [7:0]                 s12,
  output logic [7:0]                 s13,
  output logic [7:0]                 s21,
  output logic [7:0]                 s22,
  output logic [7:0]                 s23,
  output logic [7:0]                 s31,
  output logic [7:0]                 s32,
  output logic [7:0]                 s33,
  output logic                       win_valid,
  output logic                       win_last,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [XW-1:0] cur_x_s;
  logic [YW-1:0] cur_y_s;
  logic [XW-1:0] nxt_x_s;
  logic [YW-1:0] nxt_y_s;
  logic [7:0]    la_rd_s;
  logic [7:0]    lb_rd_s;
  logic          win_ok_s;
  logic          last_s;

  // LA holds line y-1, LB holds line y-2; contents are deliberately not reset
  logic [7:0] la_r [IMG_W];
  logic [7:0] lb_r [IMG_W];

  // Position of the pixel being accepted, buffer reads and next counter values
  always_comb begin
    cur_x_s = x_r;
    cur_y_s = y_r;
    nxt_x_s = x_r;
    nxt_y_s = y_r;
    if (sof) begin
      cur_x_s = {XW{1'b0}};
      cur_y_s = {YW{1'b0}};
    end else begin
      cur_x_s = x_r;
      cur_y_s = y_r;
    end
    la_rd_s = la_r[cur_x_s];
    lb_rd_s = lb_r[cur_x_s];
    if (cur_x_s == X_LAST) begin
      nxt_x_s = {XW{1'b0}};
      if (cur_y_s == Y_LAST) begin
        nxt_y_s = {YW{1'b0}};
      end else begin
        nxt_y_s = cur_y_s + YW'(1);
      end
    end else begin
      nxt_x_s = cur_x_s + XW'(1);
      nxt_y_s = cur_y_s;
    end
    // Only windows fully inside the current frame and line are flagged
    win_ok_s = (cur_x_s >= XW'(2)) && (cur_y_s >= YW'(2));
    last_s   = (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);
  end

  // Line buffer update: read-before-write at the same address
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb_r[cur_x_s] <= la_rd_s;
      la_r[cur_x_s] <= pix_in;
    end
  end

  // Counters, window shift and output flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_r       <= {XW{1'b0}};
      y_r       <= {YW{1'b0}};
      s11       <= 8'd0;
      s12       <= 8'd0;
      s13       <= 8'd0;
      s21       <= 8'd0;
      s22       <= 8'd0;
      s23       <= 8'd0;
      s31       <= 8'd0;
      s32       <= 8'd0;
      s33       <= 8'd0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_x     <= {XW{1'b0}};
      win_y     <= {YW{1'b0}};
    end else if (pix_valid) begin
      x_r       <= nxt_x_s;
      y_r       <= nxt_y_s;
      s11       <= s12;
      s12       <= s13;
      s13       <= lb_rd_s;
      s21       <= s22;
      s22       <= s23;
      s23       <= la_rd_s;
      s31       <= s32;
      s32       <= s33;
      s33       <= pix_in;
      win_valid <= win_ok_s;
      win_last  <= last_s;
      win_x     <= cur_x_s - XW'(1);
      win_y     <= cur_y_s - YW'(1);
    end else begin
      win_valid <= 1'b0;
    end
  end

endmodule
